ins_inject_ctrl: RTL and testbench

Avalon-MM slave controller that sequences instruction injection into the RV32IM core's 1024-word instruction memory from the debug SoC's Nios-side software. It holds the CPU off, takes one 32-bit instruction per register write, and drives it to the memory-side write port with an ack handshake. Each completed write auto-increments a 10-bit pointer. It replaces hand-toggling separate address/data/write-enable PIOs. Busy, error and word-count status are readable over the bus.

---
 rtl/ins_inject_ctrl.sv | 135 +++++++++++++
 tb/tb_ins_inject_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_inject_ctrl.sv
// Avalon-MM slave that injects instruction words into the RV32IM instruction memory,
// one word per DATA write, with an auto-incrementing pointer and an ack/timeout handshake.
module ins_inject_ctrl #(
    parameter int TIMEOUT    = 15,
    parameter bit HOLD_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [9:0]  inj_addr,
    output logic [31:0] inj_data,
    output logic        inj_we,
    input  logic        inj_ack,
    output logic        cpu_hold
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    localparam logic [1:0]  REG_ADDR  = 2'd0;
    localparam logic [1:0]  REG_DATA  = 2'd1;
    localparam logic [1:0]  REG_CTRL  = 2'd2;
    localparam logic [1:0]  REG_COUNT = 2'd3;
    localparam logic [3:0]  TMO       = 4'(TIMEOUT);
    localparam logic [10:0] COUNT_MAX = 11'h7FF;

    state_t      state;
    logic [9:0]  ptr;
    logic [31:0] data;
    logic [10:0] count;
    logic [3:0]  timer;
    logic        hold_reg;
    logic        err_drop;
    logic        err_timeout;

    logic busy;
    logic bus_wr;
    logic timeout_hit;

    assign busy        = (state == S_WRITE);
    assign bus_wr      = chipselect & ~write_n;
    assign timeout_hit = busy & ~inj_ack & (timer == TMO);

    assign inj_we   = busy;
    assign inj_addr = ptr;
    assign inj_data = data;
    assign cpu_hold = hold_reg | busy;

    // NOTE: all state updates use non-blocking assignments so every register sees
    // pre-edge values regardless of statement order inside the block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            ptr         <= '0;
            data        <= '0;
            count       <= '0;
            timer       <= '0;
            hold_reg    <= HOLD_RESET;
            err_drop    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (busy) begin
                if (inj_ack) begin
                    state <= S_IDLE;
                    ptr   <= ptr + 10'd1;
                    if (count != COUNT_MAX)
                        count <= count + 11'd1;
                end else if (timer == TMO) begin
                    state       <= S_IDLE;
                    err_timeout <= 1'b1;
                end else begin
                    timer <= timer + 4'd1;
                end
            end

            // Pointer/count writes are only honoured while idle, so they never
            // collide with the completion update above.
            if (bus_wr) begin
                unique case (address)
                    REG_ADDR: begin
                        if (busy) begin
                            err_drop <= 1'b1;
                        end else begin
                            ptr   <= writedata[9:0];
                            count <= '0;
                        end
                    end
                    REG_DATA: begin
                        if (!busy && hold_reg) begin
                            data  <= writedata;
                            state <= S_WRITE;
                            timer <= '0;
                        end else begin
                            err_drop <= 1'b1;
                        end
                    end
                    REG_CTRL: begin
                        hold_reg <= writedata[0];
                        if (writedata[2])
                            err_drop <= 1'b0;
                        // A timeout landing in the same cycle is a new event and stays set.
                        if (writedata[3] && !timeout_hit)
                            err_timeout <= 1'b0;
                    end
                    REG_COUNT: begin
                        if (busy)
                            err_drop <= 1'b1;
                        else
                            count <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: readdata gets a default before the case so no latch is inferred.
    always_comb begin
        readdata = '0;
        unique case (address)
            REG_ADDR:  readdata[9:0]  = ptr;
            REG_DATA:  readdata       = data;
            REG_CTRL:  readdata[3:0]  = {err_timeout, err_drop, busy, hold_reg};
            REG_COUNT: readdata[10:0] = count;
            default:   readdata       = '0;
        endcase
    end

endmodule

// File: tb/tb_ins_inject_ctrl.sv
// Self-checking bench for ins_inject_ctrl: a memory responder pops expected
// (address, word) pairs from a scoreboard on each completed handshake.
module tb_ins_inject_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [9:0]  inj_addr;
    logic [31:0] inj_data;
    logic        inj_we;
    logic        inj_ack = 1'b0;
    logic        cpu_hold;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } mem_wr_t;

    mem_wr_t sb_q[$];

    int errors = 0;
    int checks = 0;

    // Responder: 0 = ack after ack_delay cycles of inj_we, 1 = ack always high, 2 = never ack.
    int ack_mode  = 0;
    int ack_delay = 2;
    int wcnt      = 0;

    ins_inject_ctrl #(.TIMEOUT(15), .HOLD_RESET(1'b1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .inj_addr   (inj_addr),
        .inj_data   (inj_data),
        .inj_we     (inj_we),
        .inj_ack    (inj_ack),
        .cpu_hold   (cpu_hold)
    );

    always #5 clk = ~clk;

    // Acks are driven on the falling edge; the rising edge that follows completes the write.
    always @(negedge clk) begin
        if (!reset_n) begin
            inj_ack = 1'b0;
            wcnt    = 0;
        end else begin
            case (ack_mode)
                0:       inj_ack = inj_we && (wcnt >= ack_delay);
                1:       inj_ack = 1'b1;
                default: inj_ack = 1'b0;
            endcase
            if (inj_we) wcnt++; else wcnt = 0;
            if (inj_we && inj_ack) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL mem_write_unexpected: got addr=%h data=%h, expected none", inj_addr, inj_data);
                end else begin
                    mem_wr_t exp_wr;
                    exp_wr = sb_q.pop_front();
                    if (inj_addr !== exp_wr.addr || inj_data !== exp_wr.data) begin
                        errors++;
                        $display("FAIL mem_write: got addr=%h data=%h, expected addr=%h data=%h",
                                 inj_addr, inj_data, exp_wr.addr, exp_wr.data);
                    end
                end
            end
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1;
        d = readdata;
        chipselect = 1'b0;
    endtask

    task automatic push_exp(input logic [9:0] a, input logic [31:0] d);
        mem_wr_t w;
        w.addr = a;
        w.data = d;
        sb_q.push_back(w);
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (!inj_we) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_wait_idle: inj_we still 1 after 50 cycles, expected 0", name);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (cpu_hold !== 1'b1 || inj_we !== 1'b0 || inj_addr !== 10'h0 || inj_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got hold=%b we=%b addr=%h data=%h, expected 1 0 000 00000000",
                     cpu_hold, inj_we, inj_addr, inj_data);
        end
        reset_n = 1'b1;
        @(negedge clk);
        for (int r = 0; r < 4; r++) begin
            logic [31:0] exp_rd;
            exp_rd = (r == 2) ? 32'h1 : 32'h0;
            bus_read(2'(r), rd);
            checks++;
            if (rd !== exp_rd) begin
                errors++;
                $display("FAIL reset_read_reg%0d: got %h, expected %h", r, rd, exp_rd);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rd;
        ack_mode = 0; ack_delay = 2;
        bus_write(2'd0, 32'h3FE);
        push_exp(10'h3FE, 32'h00500093);
        bus_write(2'd1, 32'h00500093);
        checks++;
        if (inj_we !== 1'b1) begin
            errors++;
            $display("FAIL wrap_we_start: got inj_we=%b, expected 1", inj_we);
        end
        bus_read(2'd2, rd);
        checks++;
        if (rd !== 32'h3) begin
            errors++;
            $display("FAIL wrap_busy_read: got CTRL=%h, expected 00000003", rd);
        end
        wait_idle("wrap1");
        push_exp(10'h3FF, 32'h00100113);
        bus_write(2'd1, 32'h00100113);
        wait_idle("wrap2");
        bus_read(2'd0, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL wrap_ptr: got %h, expected 00000000", rd);
        end
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 32'h2) begin
            errors++;
            $display("FAIL wrap_count: got %h, expected 00000002", rd);
        end
        bus_read(2'd1, rd);
        checks++;
        if (rd !== 32'h00100113) begin
            errors++;
            $display("FAIL wrap_data_read: got %h, expected 00100113", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        bus_write(2'd2, 32'hD);
        bus_write(2'd0, 32'h010);
        ack_mode = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            address = 2'd1; chipselect = 1'b1; write_n = 1'b0; writedata = 32'hA000_0000 + i;
            if (i % 2 == 0) push_exp(10'(32'h010 + i / 2), 32'hA000_0000 + i);
        end
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        wait_idle("b2b");
        ack_mode = 0;
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 32'h5) begin
            errors++;
            $display("FAIL b2b_count: got %h, expected 00000005", rd);
        end
        bus_read(2'd0, rd);
        checks++;
        if (rd !== 32'h015) begin
            errors++;
            $display("FAIL b2b_ptr: got %h, expected 00000015", rd);
        end
        bus_read(2'd2, rd);
        checks++;
        if (rd !== 32'h5) begin
            errors++;
            $display("FAIL b2b_ctrl: got %h, expected 00000005", rd);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] rd;
        int          we_cycles = 0;
        bus_write(2'd2, 32'hD);
        ack_mode = 2;
        bus_write(2'd1, 32'h1234_5678);
        for (int i = 0; i < 40 && inj_we; i++) begin
            we_cycles++;
            @(negedge clk);
        end
        checks++;
        if (we_cycles != 16) begin
            errors++;
            $display("FAIL timeout_we_cycles: got %0d, expected 16", we_cycles);
        end
        bus_read(2'd2, rd);
        checks++;
        if (rd !== 32'h9) begin
            errors++;
            $display("FAIL timeout_ctrl: got %h, expected 00000009", rd);
        end
        bus_read(2'd0, rd);
        checks++;
        if (rd !== 32'h015) begin
            errors++;
            $display("FAIL timeout_ptr: got %h, expected 00000015", rd);
        end
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 32'h5) begin
            errors++;
            $display("FAIL timeout_count: got %h, expected 00000005", rd);
        end
        bus_write(2'd2, 32'h9);
        bus_read(2'd2, rd);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL timeout_clear: got %h, expected 00000001", rd);
        end
        ack_mode = 0;
    endtask

    task automatic test_hold();
        logic [31:0] rd;
        bus_write(2'd2, 32'h0);
        checks++;
        if (cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: got cpu_hold=%b, expected 0", cpu_hold);
        end
        bus_write(2'd1, 32'h0000_DEAD);
        @(negedge clk);
        checks++;
        if (inj_we !== 1'b0) begin
            errors++;
            $display("FAIL hold_drop_we: got inj_we=%b, expected 0", inj_we);
        end
        bus_read(2'd2, rd);
        checks++;
        if (rd !== 32'h4) begin
            errors++;
            $display("FAIL hold_drop_ctrl: got %h, expected 00000004", rd);
        end
        bus_write(2'd2, 32'h5);
        ack_delay = 4;
        push_exp(10'h015, 32'hCAFE_0001);
        bus_write(2'd1, 32'hCAFE_0001);
        bus_write(2'd2, 32'h0);
        checks++;
        if (cpu_hold !== 1'b1 || inj_we !== 1'b1) begin
            errors++;
            $display("FAIL hold_during_write: got hold=%b we=%b, expected 1 1", cpu_hold, inj_we);
        end
        bus_read(2'd2, rd);
        checks++;
        if (rd !== 32'h2) begin
            errors++;
            $display("FAIL hold_busy_ctrl: got %h, expected 00000002", rd);
        end
        wait_idle("hold");
        checks++;
        if (cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL hold_after_ack: got cpu_hold=%b, expected 0", cpu_hold);
        end
        ack_delay = 2;
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] rd;
        bus_write(2'd2, 32'h1);
        ack_mode = 2;
        bus_write(2'd1, 32'h5555_AAAA);
        checks++;
        if (inj_we !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_we_start: got inj_we=%b, expected 1", inj_we);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (inj_we !== 1'b0 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_async: got we=%b hold=%b, expected 0 1", inj_we, cpu_hold);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int r = 0; r < 4; r++) begin
            logic [31:0] exp_rd;
            exp_rd = (r == 2) ? 32'h1 : 32'h0;
            bus_read(2'(r), rd);
            checks++;
            if (rd !== exp_rd) begin
                errors++;
                $display("FAIL rstmid_read_reg%0d: got %h, expected %h", r, rd, exp_rd);
            end
        end
        @(negedge clk);
        checks++;
        if (inj_we !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_idle: got inj_we=%b, expected 0", inj_we);
        end
        ack_mode = 0;
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_back_to_back();
        test_timeout();
        test_hold();
        test_reset_mid_write();
        repeat (2) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending writes, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
